// File: rtl/alarm_trigger_if.sv
// Alarm trigger bus: time digits from the HH:MM counter, alarm load port,
// user controls and the alarm status outputs. The master side drives the
// time and controls; the slave side (the alarm block) drives the status.
interface alarm_trigger_if;
   // Current time from the cascaded time counter
   logic       min_tick;
   logic [3:0] u_min;
   logic [2:0] z_min;
   logic [3:0] u_hour;
   logic [1:0] z_hour;
   // Alarm time load port
   logic       alarm_set;
   logic [3:0] u_min_al_in;
   logic [2:0] z_min_al_in;
   logic [3:0] u_hour_al_in;
   logic [1:0] z_hour_al_in;
   // User controls
   logic       alarm_on;
   logic       stop;
   logic       snooze;
   // Status and stored alarm time
   logic       ring;
   logic       snoozing;
   logic       alarm_err;
   logic [3:0] u_min_al;
   logic [2:0] z_min_al;
   logic [3:0] u_hour_al;
   logic [1:0] z_hour_al;

   modport master (
      output min_tick, u_min, z_min, u_hour, z_hour,
      output alarm_set, u_min_al_in, z_min_al_in, u_hour_al_in, z_hour_al_in,
      output alarm_on, stop, snooze,
      input  ring, snoozing, alarm_err, u_min_al, z_min_al, u_hour_al, z_hour_al
   );

   modport slave (
      input  min_tick, u_min, z_min, u_hour, z_hour,
      input  alarm_set, u_min_al_in, z_min_al_in, u_hour_al_in, z_hour_al_in,
      input  alarm_on, stop, snooze,
      output ring, snoozing, alarm_err, u_min_al, z_min_al, u_hour_al, z_hour_al
   );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm trigger: stores a programmed HH:MM alarm time, rings when the running
// time reaches it (rising edge of the match only), and stops on a stop press,
// an alarm disable, a valid alarm reload or after RING_MINUTES minute ticks.
// Optional feature macro SNOOZE_EN adds a snooze state that re-rings after
// SNOOZE_MINUTES minute ticks; without it the snooze input is ignored and
// snoozing is held low.
module alarm_trigger #(
   parameter int RING_MINUTES   = 5,
   parameter int SNOOZE_MINUTES = 9
) (
   input logic          clk,
   input logic          rst_n,
   alarm_trigger_if.slave bus
);

   localparam logic [3:0] RING_LAST = 4'(RING_MINUTES - 1);
`ifdef SNOOZE_EN
   localparam logic [3:0] SNOOZE_LOAD = 4'(SNOOZE_MINUTES);

   typedef enum logic [1:0] {OFF, ARMED, RINGING, SNOOZE} stateT;
`else
   typedef enum logic [1:0] {OFF, ARMED, RINGING} stateT;
`endif

   stateT      state;
   logic [3:0] ringCnt;
   logic       ringReg;
   logic       alarmErrReg;
   logic       matchQ;
   logic [3:0] uMinAl;
   logic [2:0] zMinAl;
   logic [3:0] uHourAl;
   logic [1:0] zHourAl;
`ifdef SNOOZE_EN
   logic [3:0] snzCnt;
   logic       snoozingReg;
`endif

   logic timeValid;
   logic loadOk;
   logic loadBad;
   logic match;
   logic trigger;

   // Legal 24-hour time on the load port: 00:00 .. 23:59
   assign timeValid = (bus.z_hour_al_in <= 2'd2) &&
                      (bus.u_hour_al_in <= 4'd9) &&
                      !((bus.z_hour_al_in == 2'd2) && (bus.u_hour_al_in > 4'd3)) &&
                      (bus.z_min_al_in <= 3'd5) &&
                      (bus.u_min_al_in <= 4'd9);
   assign loadOk  = bus.alarm_set & timeValid;
   assign loadBad = bus.alarm_set & ~timeValid;

   // Pure digit equality; only the rising edge fires so a stopped alarm
   // stays quiet for the rest of the matching minute
   assign match   = bus.alarm_on &&
                    (bus.u_min == uMinAl) && (bus.z_min == zMinAl) &&
                    (bus.u_hour == uHourAl) && (bus.z_hour == zHourAl);
   assign trigger = match & ~matchQ;

   // Alarm time registers and load-error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uMinAl      <= '0;
         zMinAl      <= '0;
         uHourAl     <= '0;
         zHourAl     <= '0;
         alarmErrReg <= 1'b0;
      end else begin
         alarmErrReg <= loadBad;
         if (loadOk) begin
            uMinAl  <= bus.u_min_al_in;
            zMinAl  <= bus.z_min_al_in;
            uHourAl <= bus.u_hour_al_in;
            zHourAl <= bus.z_hour_al_in;
         end
      end
   end

   // Previous-cycle match for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) matchQ <= 1'b0;
      else        matchQ <= match;
   end

   // Alarm FSM with registered ring/snoozing outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= OFF;
         ringCnt <= '0;
         ringReg <= 1'b0;
`ifdef SNOOZE_EN
         snzCnt      <= '0;
         snoozingReg <= 1'b0;
`endif
      end else if (!bus.alarm_on) begin
         state   <= OFF;
         ringReg <= 1'b0;
`ifdef SNOOZE_EN
         snoozingReg <= 1'b0;
`endif
      end else begin
         case (state)
            OFF: begin
               state <= ARMED;
            end
            ARMED: begin
               if (trigger && !loadOk) begin
                  state   <= RINGING;
                  ringCnt <= '0;
                  ringReg <= 1'b1;
               end
            end
            RINGING: begin
               if (loadOk || bus.stop) begin
                  state   <= ARMED;
                  ringReg <= 1'b0;
`ifdef SNOOZE_EN
               end else if (bus.snooze) begin
                  state       <= SNOOZE;
                  snzCnt      <= SNOOZE_LOAD;
                  ringReg     <= 1'b0;
                  snoozingReg <= 1'b1;
`endif
               end else if (bus.min_tick) begin
                  if (ringCnt == RING_LAST) begin
                     state   <= ARMED;
                     ringReg <= 1'b0;
                  end else begin
                     ringCnt <= ringCnt + 4'd1;
                  end
               end
            end
`ifdef SNOOZE_EN
            SNOOZE: begin
               if (loadOk || bus.stop) begin
                  state       <= ARMED;
                  snoozingReg <= 1'b0;
               end else if (bus.min_tick) begin
                  if (snzCnt == 4'd1) begin
                     state       <= RINGING;
                     ringCnt     <= '0;
                     ringReg     <= 1'b1;
                     snoozingReg <= 1'b0;
                  end else begin
                     snzCnt <= snzCnt - 4'd1;
                  end
               end
            end
`endif
            default: begin
               state   <= OFF;
               ringReg <= 1'b0;
`ifdef SNOOZE_EN
               snoozingReg <= 1'b0;
`endif
            end
         endcase
      end
   end

`ifdef SNOOZE_EN
   assign bus.snoozing = snoozingReg;
`else
   logic unusedSnooze;
   assign unusedSnooze  = bus.snooze;
   assign bus.snoozing  = 1'b0;
`endif

   assign bus.ring      = ringReg;
   assign bus.alarm_err = alarmErrReg;
   assign bus.u_min_al  = uMinAl;
   assign bus.z_min_al  = zMinAl;
   assign bus.u_hour_al = uHourAl;
   assign bus.z_hour_al = zHourAl;

endmodule
